// File: rtl/sobel_pkg.sv
// Shared definitions for the streaming Sobel edge detector.
//   clog2      - ceiling log2, used for counter and address widths
//   sobel_state_t - RUN pops pixels, FLUSH drains the trailing W+1 outputs
//   mag_width  - width of |Gx|+|Gy|, wide enough that it never overflows
package sobel_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sobel_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

  function automatic int unsigned mag_width(input int unsigned pixel_width);
    return pixel_width + 4;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line pixel history for the 3x3 window.
//   clock   - rising-edge clock
//   col     - column address shared by read and write
//   wr_en   - shift the column: lb1[col] <= lb0[col], lb0[col] <= din
//   din     - newest pixel (current row)
//   rd_data - {lb1[col], lb0[col]} = {row r-2, row r-1}, read before the write
// No reset: contents before the second row of a frame are never used unmasked.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 720
) (
  input  logic                          clock,
  input  logic [clog2(IMG_WIDTH)-1:0]   col,
  input  logic                          wr_en,
  input  logic [PIXEL_WIDTH-1:0]        din,
  output logic [2*PIXEL_WIDTH-1:0]      rd_data
);

  logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];

  assign rd_data = {lb1[col], lb0[col]};

  always_ff @(posedge clock) begin
    if (wr_en) begin
      lb1[col] <= lb0[col];
      lb0[col] <= din;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming Sobel edge detector: one grayscale pixel in, one edge pixel out,
// same raster order. The 3x3 window is built from two line buffers.
//   clock, reset_n  - rising-edge clock, asynchronous active-low reset
//   fifo_in_*       - first-word-fall-through input FIFO (pop with rd_en)
//   fifo_out_*      - output FIFO write port; full stalls the whole pipeline
// Output is |Gx|+|Gy| clamped to the pixel range (THRESH_EN=0) or a binary
// decision mag > THRESHOLD (THRESH_EN=1). Border pixels always output 0.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 720,
  parameter int IMG_HEIGHT  = 540,
  parameter int THRESH_EN   = 0,
  parameter int THRESHOLD   = 128
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   fifo_in_rd_en,
  input  logic [PIXEL_WIDTH-1:0] fifo_in_dout,
  input  logic                   fifo_in_empty,
  output logic                   fifo_out_wr_en,
  output logic [PIXEL_WIDTH-1:0] fifo_out_din,
  input  logic                   fifo_out_full
);

  localparam int unsigned COL_W = clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = clog2(IMG_HEIGHT);
  localparam int unsigned FC_W  = clog2(IMG_WIDTH + 2);
  localparam int unsigned MW    = mag_width(PIXEL_WIDTH);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  sobel_state_t state_q, state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [FC_W-1:0]  flush_q;

  logic adv, pop, last_pix;
  logic centre_primed, centre_border;

  logic [2*PIXEL_WIDTH-1:0] lb_rd;
  logic [PIXEL_WIDTH-1:0]   win [3][3];  // [row][col], row 0 = top (r-2)
  logic                     s1_valid, s1_border;
  logic                     s2_valid;
  logic [PIXEL_WIDTH-1:0]   s2_data;

  logic [PIXEL_WIDTH+1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [PIXEL_WIDTH+2:0] gx, gy;
  logic [PIXEL_WIDTH+2:0]        abs_gx, abs_gy;
  logic [MW-1:0]                 mag;
  logic [PIXEL_WIDTH-1:0]        out_pix;

  assign adv      = !(s2_valid && fifo_out_full);
  // Gated by reset_n so the pop request is low while reset is held.
  assign pop      = reset_n && (state_q == RUN) && !fifo_in_empty && adv;
  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

  assign fifo_in_rd_en  = pop;
  assign fifo_out_wr_en = s2_valid && !fifo_out_full;
  assign fifo_out_din   = s2_data;

  // The popped pixel at (c,r) completes the window centred on (c-1,r-1),
  // or (W-1,r-2) when c=0. Stream index >= W+1 means r>=2 or (r==1, c>=1).
  // For a pop in RUN the centre row is at most H-2, so only x=0, x=W-1 and
  // y=0 can be border here; the bottom row is covered by FLUSH.
  assign centre_primed = (row_q >= ROW_W'(2)) || ((row_q == ROW_W'(1)) && (col_q != '0));
  assign centre_border = (col_q <= COL_W'(1)) || (row_q == ROW_W'(1));

  sobel_line_buffer #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH)
  ) u_line_buffer (
    .clock  (clock),
    .col    (col_q),
    .wr_en  (pop),
    .din    (fifo_in_dout),
    .rd_data(lb_rd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pop && last_pix) state_d = FLUSH;
      FLUSH:   if (adv && (flush_q == FC_W'(1))) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      col_q     <= '0;
      row_q     <= '0;
      flush_q   <= '0;
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q == ROW_LAST) begin
            row_q   <= '0;
            flush_q <= FC_W'(IMG_WIDTH + 1);
          end else begin
            row_q <= row_q + 1'b1;
          end
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else if ((state_q == FLUSH) && adv) begin
        flush_q <= flush_q - 1'b1;
      end

      if (adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= out_pix;
        // In FLUSH every advance injects a border item, which forces a zero.
        s1_valid  <= pop ? centre_primed : (state_q == FLUSH);
        s1_border <= pop ? centre_border : 1'b1;
      end
    end
  end

  // The window register is stage s1's data; it shifts only on a pop.
  always_ff @(posedge clock) begin
    if (pop) begin
      for (int unsigned i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb_rd[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
      win[1][2] <= lb_rd[PIXEL_WIDTH-1:0];
      win[2][2] <= fifo_in_dout;
    end
  end

  always_comb begin
    gx_pos = (PIXEL_WIDTH+2)'(win[0][2]) + (PIXEL_WIDTH+2)'({win[1][2], 1'b0}) + (PIXEL_WIDTH+2)'(win[2][2]);
    gx_neg = (PIXEL_WIDTH+2)'(win[0][0]) + (PIXEL_WIDTH+2)'({win[1][0], 1'b0}) + (PIXEL_WIDTH+2)'(win[2][0]);
    gy_pos = (PIXEL_WIDTH+2)'(win[2][0]) + (PIXEL_WIDTH+2)'({win[2][1], 1'b0}) + (PIXEL_WIDTH+2)'(win[2][2]);
    gy_neg = (PIXEL_WIDTH+2)'(win[0][0]) + (PIXEL_WIDTH+2)'({win[0][1], 1'b0}) + (PIXEL_WIDTH+2)'(win[0][2]);
    gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    abs_gx = gx[PIXEL_WIDTH+2] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy = gy[PIXEL_WIDTH+2] ? $unsigned(-gy) : $unsigned(gy);
    mag    = MW'(abs_gx) + MW'(abs_gy);

    out_pix = '0;
    if (!s1_border) begin
      if (THRESH_EN != 0) begin
        out_pix = (mag > MW'(THRESHOLD)) ? '1 : '0;
      end else begin
        out_pix = (mag > MW'((2 ** PIXEL_WIDTH) - 1)) ? '1 : mag[PIXEL_WIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Second-generation Sobel edge detector. Takes a raster-order stream of single grayscale pixels, one per FIFO word, and builds its 3x3 window internally using two line buffers. The upstream block no longer pre-packs three rows.
- Computes |Gx|+|Gy| per pixel and writes one output pixel per input pixel, in the same raster order.
- Supports two output modes: clamped magnitude, or binary threshold.
- Sits between the grayscale FIFO and the output FIFO of the image pipeline.

Parameters:
- PIXEL_WIDTH, 8, bits per grayscale pixel, in and out.
- IMG_WIDTH, 720, pixels per row; must be at least 4.
- IMG_HEIGHT, 540, rows per frame; must be at least 3.
- THRESH_EN, 0, 0 = clamped magnitude output, 1 = binary threshold output.
- THRESHOLD, 128, threshold compared against the unclamped magnitude when THRESH_EN=1.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_in_rd_en  out  1  pop request; input FIFO is first-word-fall-through.
- fifo_in_dout  in  PIXEL_WIDTH  grayscale pixel; valid whenever fifo_in_empty=0.
- fifo_in_empty  in  1  input FIFO empty.
- fifo_out_wr_en  out  1  write strobe to output FIFO.
- fifo_out_din  out  PIXEL_WIDTH  edge pixel.
- fifo_out_full  in  1  output FIFO full.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - fifo_in_rd_en=0, fifo_out_wr_en=0, fifo_out_din=0.
  - col/row counters=0, state=RUN, both pipeline valids=0.
  - Line-buffer RAM and window contents are not reset.
  - Reset mid-frame abandons the frame; the next pixel accepted is treated as (0,0).
- Pipeline advance: adv = !(s2_valid && fifo_out_full).
- fifo_out_wr_en = s2_valid && !fifo_out_full, driven combinationally. fifo_out_din is the s2 register.
- Input pop: fifo_in_rd_en = (state==RUN) && !fifo_in_empty && adv.
- On a pop of pixel p at (col c, row r):
  - Line buffers update: lb1[c] <= lb0[c], lb0[c] <= p.
  - Window shifts one column left; its new right column is {lb1[c], lb0[c], p} (rows r-2, r-1, r).
  - The window is now centred on (c-1, r-1), with wrap to (W-1, r-2) when c=0.
- Output rule: output index k is emitted when input index k+W+1 is popped, where W=IMG_WIDTH and H=IMG_HEIGHT. The remaining W+1 outputs are emitted in FLUSH.
- Stage s1 (on pop): register the window and a centre-is-border flag. Border means x==0, x==W-1, y==0 or y==H-1. s1_valid is set only once the stream index is at least W+1.
- Stage s2 (on adv): compute and register the output.
  - Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Both are signed PIXEL_WIDTH+3 bits. mag = |Gx|+|Gy| is unsigned PIXEL_WIDTH+4 bits and cannot overflow.
  - THRESH_EN=0: out = min(mag, 2^PIXEL_WIDTH-1).
  - THRESH_EN=1: out = (mag > THRESHOLD) ? all-ones : 0.
  - Border pixel: out = 0 in either mode.
- Latency: pixel popped in cycle N produces its associated output with wr_en earliest in cycle N+2. Sustained throughput is 1 pixel/cycle.
- Backpressure: when fifo_out_full=1 and s2_valid=1, all stages hold, rd_en=0 and nothing is lost. The full flag is sampled combinationally in the same cycle.
- States:
  - RUN: pop pixels. When the last pixel (W-1, H-1) is popped, go to FLUSH with flush_cnt=W+1.
  - FLUSH: no pops. On each adv, inject a border-zero item into s1 and decrement flush_cnt. When flush_cnt reaches 0, counters clear and the state returns to RUN.
  - All flush outputs are 0, since they are the last row plus (W-1, H-2).
- Counter wrap: col wraps at W-1 and increments row; row wraps at H-1 into FLUSH. Exactly W*H outputs are produced per frame.
- Empty mid-frame: the pipeline drains what it holds, no bubbles are written, and state is kept.
- Simultaneous full and empty: stall; nothing is popped or written.

Decomposition:
- Package sobel_pkg holds:
  - function clog2;
  - state encodings RUN=1'b0, FLUSH=1'b1;
  - function mag_width(PIXEL_WIDTH)=PIXEL_WIDTH+4.
- Sub-module sobel_line_buffer: a two-line buffer of depth IMG_WIDTH × PIXEL_WIDTH with a column address and a write enable, returning {lb1[c], lb0[c]}. It is infer-friendly single-port RAM per line with read-before-write.

Test Plan (W=8, H=6, PIXEL_WIDTH=8 unless stated):
- Flat frame, all pixels 100, fifo_in_empty never asserted -> exactly 48 writes, all 0. First write lands 2 cycles after the 10th pop; the last write lands within W+1+2 cycles of the final pop.
- Vertical edge: columns 0-3 = 0, columns 4-7 = 200 -> interior pixels at x=3 and x=4 output 255 (mag 800, clamped). All other interior pixels and all border pixels output 0.
- Same frame with THRESH_EN=1, THRESHOLD=500 -> x=3,4 interior = 8'hFF, everything else 0. With THRESHOLD=800 -> all 0 (strictly-greater test).
- Backpressure: hold fifo_out_full=1 for 5 cycles mid-frame, and toggle fifo_in_empty randomly -> output sequence identical to the unstalled run. rd_en=0 while full and s2_valid are both high.
- Back-to-back frames: two different frames with no gap -> 96 outputs. Frame 2 output is uncorrupted by frame 1, and the FLUSH→RUN handover pops frame-2 pixel (0,0).
- Reset: assert reset_n=0 asynchronously mid-row 3, then send a fresh frame -> outputs go 0 immediately with no clock edge, and the new frame's 48 outputs match the reference model.
